// File: rtl/vram_buffer_ctrl_pkg.sv
// Shared constants and types for the double-buffered 16x8 RGB LED frame store.
//   VRAM_W/VRAM_H : panel geometry in pixels
//   PIX_BITS      : packed {red, green, blue} pixel width
//   state_e       : controller FSM encoding
package vram_buffer_ctrl_pkg;

  localparam int unsigned VRAM_W   = 16;
  localparam int unsigned VRAM_H   = 8;
  localparam int unsigned PIX_BITS = 24;

  localparam int unsigned CHAN_W   = PIX_BITS / 3;
  localparam int unsigned X_W      = $clog2(VRAM_W);
  localparam int unsigned Y_W      = $clog2(VRAM_H);
  localparam int unsigned PAGE_PIX = VRAM_W * VRAM_H;
  localparam int unsigned CLR_W    = $clog2(PAGE_PIX);
  // One extra address bit selects the page.
  localparam int unsigned ADDR_W   = CLR_W + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StClear   = 2'd2,
    StAck     = 2'd3
  } state_e;

  // RAM address layout is {page, y, x}; offs is the in-page {y, x} index.
  function automatic logic [ADDR_W-1:0] vram_addr(input logic page,
                                                  input logic [CLR_W-1:0] offs);
    return {page, offs};
  endfunction

endpackage

// File: rtl/vram_buffer_ctrl_if.sv
// Bus bundle between the graphics generator / display scanner (master) and the
// frame-store controller (slave).
//   write side : wr_x, wr_y, wr_red/green/blue, wr_valid, flip_req -> ; <- flipped
//   read side  : rd_x, rd_y, rd_en, frame_end -> ; <- rd_red/green/blue, rd_valid
//   status     : <- busy, wr_overrun
interface vram_buffer_ctrl_if;
  import vram_buffer_ctrl_pkg::*;

  logic [X_W-1:0]    wr_x;
  logic [Y_W-1:0]    wr_y;
  logic [CHAN_W-1:0] wr_red;
  logic [CHAN_W-1:0] wr_green;
  logic [CHAN_W-1:0] wr_blue;
  logic              wr_valid;
  logic              flip_req;
  logic              flipped;

  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic              rd_en;
  logic              frame_end;
  logic [CHAN_W-1:0] rd_red;
  logic [CHAN_W-1:0] rd_green;
  logic [CHAN_W-1:0] rd_blue;
  logic              rd_valid;

  logic              busy;
  logic              wr_overrun;

  modport master (
    output wr_x, wr_y, wr_red, wr_green, wr_blue, wr_valid, flip_req,
    output rd_x, rd_y, rd_en, frame_end,
    input  flipped, rd_red, rd_green, rd_blue, rd_valid, busy, wr_overrun
  );

  modport slave (
    input  wr_x, wr_y, wr_red, wr_green, wr_blue, wr_valid, flip_req,
    input  rd_x, rd_y, rd_en, frame_end,
    output flipped, rd_red, rd_green, rd_blue, rd_valid, busy, wr_overrun
  );

endinterface

// File: rtl/vram_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_re    : read enable
//   i_raddr : read address
//   o_rdata : registered read data (valid the cycle after i_re)
module vram_dp_ram #(
  parameter int unsigned AddrW = 8,
  parameter int unsigned DataW = 24
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AddrW-1:0] i_raddr,
  output logic [DataW-1:0] o_rdata
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] r_mem [Depth];
  logic [DataW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_buffer_ctrl.sv
// Double-buffer controller for the 16x8 RGB LED frame store. The generator
// writes the back page, the scanner reads the front page. A flip request waits
// for the scanner's end-of-frame, swaps pages, optionally zeroes the new back
// page, then pulses flipped.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   vram_bus : slave side of vram_buffer_ctrl_if (write, read and status signals)
// Parameter CLEAR_ON_FLIP: 1 = zero the new back page after each swap.
module vram_buffer_ctrl
  import vram_buffer_ctrl_pkg::*;
#(
  parameter bit CLEAR_ON_FLIP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  vram_buffer_ctrl_if.slave   vram_bus
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_front;
  logic [CLR_W-1:0]    r_clr_addr;
  logic [CLR_W-1:0]    w_clr_addr_nxt;
  logic                r_overrun;
  logic                r_rd_valid;

  logic                w_swap;
  logic                w_gen_wr_ok;
  logic                w_drop;
  logic                w_clearing;

  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_waddr;
  logic [PIX_BITS-1:0] w_ram_wdata;
  logic [ADDR_W-1:0]   w_ram_raddr;
  logic [PIX_BITS-1:0] w_ram_rdata;

  // Next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_swap         = 1'b0;
    w_gen_wr_ok    = 1'b0;
    w_drop         = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_gen_wr_ok = 1'b1;
        if (vram_bus.flip_req) begin
          if (vram_bus.frame_end) begin
            w_swap      = 1'b1;
            w_state_nxt = CLEAR_ON_FLIP ? StClear : StAck;
          end else begin
            w_state_nxt = StPending;
          end
        end
      end
      StPending: begin
        // A repeated flip_req here is ignored; only frame_end moves on.
        w_drop = vram_bus.wr_valid;
        if (vram_bus.frame_end) begin
          w_swap      = 1'b1;
          w_state_nxt = CLEAR_ON_FLIP ? StClear : StAck;
        end
      end
      StClear: begin
        w_drop         = vram_bus.wr_valid;
        // Wraps back to 0 after the last word, ready for the next clear.
        w_clr_addr_nxt = r_clr_addr + CLR_W'(1);
        if (r_clr_addr == '1) begin
          w_state_nxt = StAck;
        end
      end
      StAck: begin
        w_gen_wr_ok = 1'b1;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Write port is shared between the generator and the clear sweep; both
  // always target the current back page.
  always_comb begin
    w_clearing  = (r_state == StClear);
    w_ram_we    = w_clearing | (w_gen_wr_ok & vram_bus.wr_valid);
    w_ram_waddr = vram_addr(~r_front, {vram_bus.wr_y, vram_bus.wr_x});
    w_ram_wdata = {vram_bus.wr_red, vram_bus.wr_green, vram_bus.wr_blue};
    if (w_clearing) begin
      w_ram_waddr = vram_addr(~r_front, r_clr_addr);
      w_ram_wdata = '0;
    end
  end

  // Read address uses the registered front bit, so a read issued in the swap
  // cycle still sees the old front page.
  assign w_ram_raddr = vram_addr(r_front, {vram_bus.rd_y, vram_bus.rd_x});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_front    <= 1'b0;
      r_clr_addr <= '0;
      r_overrun  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_overrun  <= r_overrun | w_drop;
      r_rd_valid <= vram_bus.rd_en;
      if (w_swap) begin
        r_front <= ~r_front;
      end
    end
  end

  vram_dp_ram #(
    .AddrW (ADDR_W),
    .DataW (PIX_BITS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (vram_bus.rd_en),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  assign vram_bus.flipped    = (r_state == StAck);
  assign vram_bus.busy       = (r_state == StPending) || (r_state == StClear);
  assign vram_bus.wr_overrun = r_overrun;
  assign vram_bus.rd_valid   = r_rd_valid;
  // RAM output is unreset; gating keeps the read data at zero out of reset.
  assign {vram_bus.rd_red, vram_bus.rd_green, vram_bus.rd_blue} =
    r_rd_valid ? w_ram_rdata : '0;

endmodule

// File: tb/tb_vram_buffer_ctrl.sv
module tb_vram_buffer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [23:0] q1[$];
  logic [23:0] q0[$];
  logic [23:0] exp1;
  logic [23:0] exp0;

  always #5 clk = ~clk;

  vram_buffer_ctrl_if b1();
  vram_buffer_ctrl_if b0();

  vram_buffer_ctrl #(.CLEAR_ON_FLIP(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .vram_bus (b1)
  );

  vram_buffer_ctrl #(.CLEAR_ON_FLIP(1'b0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .vram_bus (b0)
  );

  // Read scoreboards: expected pixels pushed at rd_en, popped on rd_valid.
  always @(negedge clk) begin
    if (!rst && b1.rd_valid) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL rd1_unexpected: got rd_valid=1 data=%06h, required no pending read",
                 {b1.rd_red, b1.rd_green, b1.rd_blue});
      end else begin
        exp1 = q1.pop_front();
        if ({b1.rd_red, b1.rd_green, b1.rd_blue} !== exp1) begin
          n_fail++;
          $display("FAIL rd1_data: got %06h, required %06h",
                   {b1.rd_red, b1.rd_green, b1.rd_blue}, exp1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b0.rd_valid) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL rd0_unexpected: got rd_valid=1 data=%06h, required no pending read",
                 {b0.rd_red, b0.rd_green, b0.rd_blue});
      end else begin
        exp0 = q0.pop_front();
        if ({b0.rd_red, b0.rd_green, b0.rd_blue} !== exp0) begin
          n_fail++;
          $display("FAIL rd0_data: got %06h, required %06h",
                   {b0.rd_red, b0.rd_green, b0.rd_blue}, exp0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b1.wr_x = '0; b1.wr_y = '0; b1.wr_red = '0; b1.wr_green = '0; b1.wr_blue = '0;
    b1.wr_valid = 1'b0; b1.flip_req = 1'b0; b1.rd_x = '0; b1.rd_y = '0;
    b1.rd_en = 1'b0; b1.frame_end = 1'b0;
    b0.wr_x = '0; b0.wr_y = '0; b0.wr_red = '0; b0.wr_green = '0; b0.wr_blue = '0;
    b0.wr_valid = 1'b0; b0.flip_req = 1'b0; b0.rd_x = '0; b0.rd_y = '0;
    b0.rd_en = 1'b0; b0.frame_end = 1'b0;
  endtask

  task automatic wr1(input int x, input int y, input logic [23:0] d);
    b1.wr_x = 4'(x); b1.wr_y = 3'(y);
    {b1.wr_red, b1.wr_green, b1.wr_blue} = d;
    b1.wr_valid = 1'b1;
    tick();
    b1.wr_valid = 1'b0;
  endtask

  task automatic wr0(input int x, input int y, input logic [23:0] d);
    b0.wr_x = 4'(x); b0.wr_y = 3'(y);
    {b0.wr_red, b0.wr_green, b0.wr_blue} = d;
    b0.wr_valid = 1'b1;
    tick();
    b0.wr_valid = 1'b0;
  endtask

  task automatic fill1(input logic [23:0] d);
    for (int a = 0; a < 128; a++) begin
      b1.wr_x = a[3:0]; b1.wr_y = a[6:4];
      {b1.wr_red, b1.wr_green, b1.wr_blue} = d;
      b1.wr_valid = 1'b1;
      tick();
    end
    b1.wr_valid = 1'b0;
  endtask

  task automatic rd1(input int x, input int y, input logic [23:0] d);
    b1.rd_x = 4'(x); b1.rd_y = 3'(y); b1.rd_en = 1'b1;
    q1.push_back(d);
    tick();
    b1.rd_en = 1'b0;
  endtask

  task automatic rd0(input int x, input int y, input logic [23:0] d);
    b0.rd_x = 4'(x); b0.rd_y = 3'(y); b0.rd_en = 1'b1;
    q0.push_back(d);
    tick();
    b0.rd_en = 1'b0;
  endtask

  task automatic rd_all1(input logic [23:0] d);
    for (int a = 0; a < 128; a++) begin
      b1.rd_x = a[3:0]; b1.rd_y = a[6:4]; b1.rd_en = 1'b1;
      q1.push_back(d);
      tick();
    end
    b1.rd_en = 1'b0;
  endtask

  // Immediate flip on dut; lat = cycles from the first post-swap cycle to flipped, -1 if never.
  task automatic flip1(output int lat);
    b1.flip_req = 1'b1; b1.frame_end = 1'b1;
    tick();
    b1.flip_req = 1'b0; b1.frame_end = 1'b0;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (b1.flipped === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({b1.flipped, b1.busy, b1.rd_valid, b1.wr_overrun, b1.rd_red, b1.rd_green, b1.rd_blue}
        !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_dut: got flipped=%b busy=%b rd_valid=%b overrun=%b data=%06h, required all 0",
               b1.flipped, b1.busy, b1.rd_valid, b1.wr_overrun,
               {b1.rd_red, b1.rd_green, b1.rd_blue});
    end
    n_checks++;
    if ({b0.flipped, b0.busy, b0.rd_valid, b0.wr_overrun, b0.rd_red, b0.rd_green, b0.rd_blue}
        !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_dut0: got flipped=%b busy=%b rd_valid=%b overrun=%b data=%06h, required all 0",
               b0.flipped, b0.busy, b0.rd_valid, b0.wr_overrun,
               {b0.rd_red, b0.rd_green, b0.rd_blue});
    end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({b1.flipped, b1.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got flipped,busy=%b, required 00", {b1.flipped, b1.busy});
    end
  endtask

  task automatic test_write_flip();
    int first_bad;
    wr1(3, 2, 24'h112233);
    n_checks++;
    if (b1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wf_idle_busy: got %b, required 0", b1.busy);
    end
    b1.flip_req = 1'b1; b1.frame_end = 1'b1;
    tick();
    b1.flip_req = 1'b0; b1.frame_end = 1'b0;
    first_bad = -1;
    for (int k = 0; k < 128; k++) begin
      if ((b1.busy !== 1'b1 || b1.flipped !== 1'b0) && first_bad < 0) first_bad = k;
      tick();
    end
    n_checks++;
    if (first_bad != -1) begin
      n_fail++;
      $display("FAIL wf_clear_window: got bad busy/flipped at clear cycle %0d, required none",
               first_bad);
    end
    n_checks++;
    if ({b1.flipped, b1.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL wf_ack_cycle: got flipped,busy=%b, required 10", {b1.flipped, b1.busy});
    end
    tick();
    n_checks++;
    if ({b1.flipped, b1.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL wf_after_ack: got flipped,busy=%b, required 00", {b1.flipped, b1.busy});
    end
    rd1(3, 2, 24'h112233);
    tick(); tick();
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL wf_reads_done: got %0d outstanding, required 0", q1.size());
    end
  endtask

  task automatic test_pending();
    int first_bad;
    // Stray frame_end in IDLE must be ignored and not remembered.
    b1.frame_end = 1'b1;
    tick();
    b1.frame_end = 1'b0;
    n_checks++;
    if ({b1.busy, b1.flipped} !== 2'b00) begin
      n_fail++;
      $display("FAIL pd_stray_frame_end: got busy,flipped=%b, required 00",
               {b1.busy, b1.flipped});
    end
    tick();
    b1.flip_req = 1'b1;                // cycle 10
    tick();
    b1.flip_req = 1'b0;
    first_bad = -1;
    for (int k = 0; k < 39; k++) begin // cycles 11..49, second flip_req at 20
      if ((b1.busy !== 1'b1 || b1.flipped !== 1'b0) && first_bad < 0) first_bad = k + 11;
      b1.flip_req = (k == 9);
      tick();
    end
    b1.flip_req = 1'b0;
    n_checks++;
    if (first_bad != -1) begin
      n_fail++;
      $display("FAIL pd_wait_window: got bad busy/flipped in cycle %0d, required busy=1 flipped=0",
               first_bad);
    end
    b1.frame_end = 1'b1;               // cycle 50
    n_checks++;
    if (b1.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pd_busy_c50: got %b, required 1", b1.busy);
    end
    tick();
    b1.frame_end = 1'b0;
    first_bad = -1;
    for (int k = 0; k < 128; k++) begin // cycles 51..178
      if ((b1.busy !== 1'b1 || b1.flipped !== 1'b0) && first_bad < 0) first_bad = k + 51;
      tick();
    end
    n_checks++;
    if (first_bad != -1) begin
      n_fail++;
      $display("FAIL pd_clear_window: got bad busy/flipped in cycle %0d, required busy=1 flipped=0",
               first_bad);
    end
    n_checks++;
    if ({b1.flipped, b1.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL pd_ack_c179: got flipped,busy=%b, required 10", {b1.flipped, b1.busy});
    end
    tick();
    first_bad = -1;
    for (int k = 0; k < 6; k++) begin
      if ((b1.busy !== 1'b0 || b1.flipped !== 1'b0) && first_bad < 0) first_bad = k + 180;
      tick();
    end
    n_checks++;
    if (first_bad != -1) begin
      n_fail++;
      $display("FAIL pd_single_pulse: got activity in cycle %0d, required idle", first_bad);
    end
    rd1(3, 2, 24'h000000);
    tick(); tick();
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL pd_reads_done: got %0d outstanding, required 0", q1.size());
    end
  endtask

  task automatic test_clear();
    int lat;
    fill1(24'hFFFFFF);           // back page 1
    flip1(lat);                  // front 1, page 0 cleared
    n_checks++;
    if (lat != 128) begin
      n_fail++;
      $display("FAIL cl_lat_a: got %0d, required 128", lat);
    end
    rd_all1(24'hFFFFFF);
    fill1(24'hFFFFFF);           // back page 0
    flip1(lat);                  // front 0, page 1 cleared
    n_checks++;
    if (lat != 128) begin
      n_fail++;
      $display("FAIL cl_lat_b: got %0d, required 128", lat);
    end
    rd_all1(24'hFFFFFF);
    flip1(lat);                  // front 1, page 0 cleared
    rd_all1(24'h000000);
    flip1(lat);                  // front 0
    rd_all1(24'h000000);
    tick(); tick();
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL cl_reads_done: got %0d outstanding, required 0", q1.size());
    end
  endtask

  task automatic test_overrun();
    int lat;
    n_checks++;
    if (b1.wr_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ov_initial: got %b, required 0", b1.wr_overrun);
    end
    b1.flip_req = 1'b1;
    tick();
    b1.flip_req = 1'b0;
    n_checks++;
    if (b1.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ov_pending_busy: got %b, required 1", b1.busy);
    end
    wr1(5, 6, 24'hABCDEF);       // dropped
    n_checks++;
    if (b1.wr_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ov_set: got %b, required 1", b1.wr_overrun);
    end
    b1.frame_end = 1'b1;
    tick();                      // swap: front 1, clearing page 0
    b1.frame_end = 1'b0;
    repeat (4) tick();
    wr1(0, 0, 24'h777777);       // dropped during clear, after word 0 was cleared
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (b1.flipped === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    tick();
    n_checks++;
    if (lat != 123) begin
      n_fail++;
      $display("FAIL ov_flip_lat: got %0d, required 123", lat);
    end
    n_checks++;
    if (b1.wr_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ov_sticky: got %b, required 1", b1.wr_overrun);
    end
    rd1(5, 6, 24'h000000);
    flip1(lat);                  // front 0
    rd1(0, 0, 24'h000000);
    tick(); tick();
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL ov_reads_done: got %0d outstanding, required 0", q1.size());
    end
  endtask

  task automatic test_no_clear();
    wr0(7, 7, 24'h445566);
    // Flip with a write in the same cycle: the write lands on the old back page.
    b0.wr_x = 4'd8; b0.wr_y = 3'd1;
    {b0.wr_red, b0.wr_green, b0.wr_blue} = 24'h778899;
    b0.wr_valid = 1'b1; b0.flip_req = 1'b1; b0.frame_end = 1'b1;
    tick();                      // swap edge N
    b0.flip_req = 1'b0; b0.frame_end = 1'b0;
    n_checks++;
    if ({b0.flipped, b0.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL nc_ack1: got flipped,busy=%b, required 10", {b0.flipped, b0.busy});
    end
    // Write during ACK goes to the new back page 0.
    b0.wr_x = 4'd1; b0.wr_y = 3'd1;
    {b0.wr_red, b0.wr_green, b0.wr_blue} = 24'h0A0B0C;
    tick();
    b0.wr_valid = 1'b0;
    n_checks++;
    if ({b0.flipped, b0.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL nc_idle1: got flipped,busy=%b, required 00", {b0.flipped, b0.busy});
    end
    rd0(7, 7, 24'h445566);
    rd0(8, 1, 24'h778899);
    // Read in the swap cycle must still see old front page 1.
    b0.flip_req = 1'b1; b0.frame_end = 1'b1;
    b0.rd_x = 4'd7; b0.rd_y = 3'd7; b0.rd_en = 1'b1;
    q0.push_back(24'h445566);
    tick();
    b0.flip_req = 1'b0; b0.frame_end = 1'b0; b0.rd_en = 1'b0;
    n_checks++;
    if (b0.flipped !== 1'b1) begin
      n_fail++;
      $display("FAIL nc_ack2: got %b, required 1", b0.flipped);
    end
    tick();
    rd0(1, 1, 24'h0A0B0C);
    b0.flip_req = 1'b1; b0.frame_end = 1'b1;
    tick();
    b0.flip_req = 1'b0; b0.frame_end = 1'b0;
    n_checks++;
    if (b0.flipped !== 1'b1) begin
      n_fail++;
      $display("FAIL nc_ack3: got %b, required 1", b0.flipped);
    end
    tick();
    rd0(7, 7, 24'h445566);       // old content retained, no clear
    rd0(8, 1, 24'h778899);
    tick(); tick();
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL nc_reads_done: got %0d outstanding, required 0", q0.size());
    end
    n_checks++;
    if (b0.wr_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL nc_overrun: got %b, required 0", b0.wr_overrun);
    end
  endtask

  task automatic test_reset_mid_clear();
    int lat;
    int first_bad;
    wr1(4, 4, 24'h123456);       // back page 1
    b1.flip_req = 1'b1; b1.frame_end = 1'b1;
    tick();                      // swap: front 1, clearing page 0 from word 0
    b1.flip_req = 1'b0; b1.frame_end = 1'b0;
    repeat (60) tick();          // clr_addr = 60
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({b1.flipped, b1.busy, b1.rd_valid, b1.wr_overrun, b1.rd_red, b1.rd_green, b1.rd_blue}
        !== 28'h0) begin
      n_fail++;
      $display("FAIL rm_async: got flipped=%b busy=%b rd_valid=%b overrun=%b data=%06h, required all 0",
               b1.flipped, b1.busy, b1.rd_valid, b1.wr_overrun,
               {b1.rd_red, b1.rd_green, b1.rd_blue});
    end
    tick();
    rst = 1'b0;
    first_bad = -1;
    for (int k = 0; k < 140; k++) begin
      if ((b1.flipped !== 1'b0 || b1.busy !== 1'b0) && first_bad < 0) first_bad = k;
      tick();
    end
    n_checks++;
    if (first_bad != -1) begin
      n_fail++;
      $display("FAIL rm_no_flipped: got activity %0d cycles after reset, required idle",
               first_bad);
    end
    // front is back to 0: page 0 word 68 was beyond the aborted sweep and holds 0.
    rd1(4, 4, 24'h000000);
    wr1(2, 2, 24'h5A5A5A);       // back page 1
    flip1(lat);
    n_checks++;
    if (lat != 128) begin
      n_fail++;
      $display("FAIL rm_flip_lat: got %0d, required 128", lat);
    end
    rd1(4, 4, 24'h123456);
    rd1(2, 2, 24'h5A5A5A);
    tick(); tick();
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL rm_reads_done: got %0d outstanding, required 0", q1.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_flip();
    test_pending();
    test_clear();
    test_overrun();
    test_no_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_buffer_ctrl.md
# vram_buffer_ctrl

Double-buffer controller for the 16x8 RGB LED frame store. It sits between the graphics generator (write side) and the display scanner (read side). It owns a 2-page VRAM: generator writes go to the back page and scanner reads come from the front page. On a generator flip request it waits for the scanner's end-of-frame, swaps pages, optionally clears the new back page, and then pulses `flipped`.

## Interface
Parameters:
- `CLEAR_ON_FLIP`, default 1: when 1, zero the new back page after each swap before acknowledging.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_x`  in  4  back-page column
- `wr_y`  in  3  back-page row
- `wr_red`, `wr_green`, `wr_blue`  in  8 each  pixel color
- `wr_valid`  in  1  write strobe
- `flip_req`  in  1  single-cycle pulse: back page complete
- `flipped`  out  1  single-cycle pulse: swap (and clear) done, new back page writable
- `rd_x`  in  4  front-page column
- `rd_y`  in  3  front-page row
- `rd_en`  in  1  read strobe
- `frame_end`  in  1  single-cycle pulse from scanner after its last read of a frame
- `rd_red`, `rd_green`, `rd_blue`  out  8 each  read data
- `rd_valid`  out  1  read data valid
- `busy`  out  1  high in PENDING or CLEAR
- `wr_overrun`  out  1  sticky flag: a write was dropped

## Operation
- The front-page select bit `front` resets to 0. The back page is `~front`.
- RAM address is {page, y, x}, 8 bits, giving 256 x 24 bits.
- States:
  - IDLE
    - `wr_valid` writes pixel data to the back page.
    - `flip_req` with `frame_end` in the same cycle: swap on this edge and go to CLEAR, or to ACK if `CLEAR_ON_FLIP`=0.
    - `flip_req` alone: go to PENDING.
    - A write in the same cycle as `flip_req` is accepted.
  - PENDING
    - Waits for `frame_end`. On `frame_end`, swap on that edge and go to CLEAR or ACK.
    - `wr_valid` is dropped and sets `wr_overrun`.
    - A second `flip_req` is ignored.
  - CLEAR
    - A 7-bit `clr_addr` runs 0..127, writing 24'h0 to {~front, clr_addr}, one per cycle.
    - After the write of 127, go to ACK.
    - `wr_valid` is dropped and sets `wr_overrun`.
  - ACK
    - `flipped`=1 for exactly one cycle, then return to IDLE.
    - Writes in ACK are accepted.
- A swap toggles `front` at the clock edge. A read issued in the swap cycle still uses the old front page.
- The read port is independent of the FSM and is never stalled.
- `wr_overrun` is cleared only by reset.
- `frame_end` in IDLE or CLEAR without a pending flip is ignored. It does not latch.

## Timing
- Reset values: `flipped`=0, `rd_valid`=0, `rd_*` data=0, `busy`=0, `wr_overrun`=0, state=IDLE, `front`=0, `clr_addr`=0.
- RAM contents are not reset.
- Read latency is 1 cycle. `rd_en` at edge N gives `rd_valid` and data high during cycle N+1. Back-to-back reads are supported every cycle.
- Write latency is 1 cycle. A written pixel becomes visible on the front page only after a subsequent swap.
- With `CLEAR_ON_FLIP`=1, `flipped` rises 129 cycles after the swap edge: 128 clear cycles plus the ACK cycle.
- With `CLEAR_ON_FLIP`=0, `flipped` is high in the cycle immediately after the swap edge.
- `busy` is high from the cycle after `flip_req` (or from the swap) until the ACK cycle. It is low in ACK.
- Reset mid-CLEAR: the FSM returns to IDLE, `front`=0, and there is no `flipped` pulse. The partially cleared page is left as is.

## Structure
- Shared package holds:
  - the `VRAM_W`=16, `VRAM_H`=8 and `PIX_BITS`=24 constants
  - the 2-bit state encoding: IDLE, PENDING, CLEAR, ACK
- One sub-module, `vram_dp_ram`: 256x24, one synchronous write port and one synchronous read port, no reset.
  - The controller muxes the write port between the generator and the clear logic.

## Test plan
- **Write then flip with immediate `frame_end`:** write (3,2)=0x112233 to page 1, pulse `flip_req`+`frame_end` together → `front`=1, `flipped` 129 cycles later, read (3,2) → 0x112233 one cycle after `rd_en`.
- **Flip pends for the scanner:** `flip_req` in cycle 10, `frame_end` in cycle 50 → `busy` high in cycles 11–178, swap at cycle 50, `flipped` high in cycle 179 only.
- **Clear check:** fill page 0 with 0xFFFFFF, flip twice → the back page reads 24'h0 at all 128 addresses.
- **Overrun:** `wr_valid` during PENDING → RAM unchanged, `wr_overrun`=1 until reset.
- **`CLEAR_ON_FLIP`=0:** swap at edge N → `flipped` in cycle N+1, old page contents retained.
- **Async reset during CLEAR at `clr_addr`=60:** all outputs at reset values immediately, no `flipped`, next `flip_req` works normally.
